// File: rtl/comparison_unit_pkg.sv
// Shared ALU definitions: relational opcodes and the decode helper used by the comparison unit.
// Decoding is pure combinational logic with no flow control of its own.
package comparison_unit_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] IS_EQ  = 4'b0000;
    localparam logic [OPCODE_WIDTH-1:0] IS_NE  = 4'b0001;
    localparam logic [OPCODE_WIDTH-1:0] IS_GE  = 4'b0010;
    localparam logic [OPCODE_WIDTH-1:0] IS_LT  = 4'b0011;
    localparam logic [OPCODE_WIDTH-1:0] IS_GEU = 4'b0110;
    localparam logic [OPCODE_WIDTH-1:0] IS_LTU = 4'b0111;

    typedef enum logic [1:0] {
        SRC_EQ  = 2'd0,
        SRC_LTU = 2'd1,
        SRC_LT  = 2'd2
    } cmp_src_t;

    typedef struct packed {
        logic     legal;
        cmp_src_t src;
        logic     invert;
    } op_dec_t;

    // Every opcode is one of three core outputs, optionally complemented.
    function automatic op_dec_t decode_op(input logic [OPCODE_WIDTH-1:0] op);
        op_dec_t d;
        d.legal  = 1'b1;
        d.src    = SRC_EQ;
        d.invert = 1'b0;
        case (op)
            IS_EQ:   begin d.src = SRC_EQ;  d.invert = 1'b0; end
            IS_NE:   begin d.src = SRC_EQ;  d.invert = 1'b1; end
            IS_GE:   begin d.src = SRC_LT;  d.invert = 1'b1; end
            IS_LT:   begin d.src = SRC_LT;  d.invert = 1'b0; end
            IS_GEU:  begin d.src = SRC_LTU; d.invert = 1'b1; end
            IS_LTU:  begin d.src = SRC_LTU; d.invert = 1'b0; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/comparison_unit_core.sv
// Purpose: equality, unsigned less-than and signed less-than of two operands.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module comparison_core #(
    parameter int OPD_LENGTH = 8
) (
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    output logic                  eq,
    output logic                  ltu,
    output logic                  lt
);

    logic sign_differs;

    always_comb begin
        eq           = (opd1 == opd2);
        ltu          = (opd1 < opd2);
        sign_differs = opd1[OPD_LENGTH-1] ^ opd2[OPD_LENGTH-1];
        // With differing signs the negative operand is smaller; otherwise the
        // unsigned order matches the two's-complement order, so no overflow.
        lt           = sign_differs ? opd1[OPD_LENGTH-1] : ltu;
    end

endmodule

// File: rtl/comparison_unit.sv
// Purpose: ALU relational subunit (EQ/NE/GE/GEU/LT/LTU) with illegal-opcode flag.
// Latency: one cycle, registered outputs, one request per cycle.
// Backpressure: none; outputs hold when in_valid is low.
module comparison_unit
    import comparison_unit_pkg::*;
#(
    parameter int OPD_LENGTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [OPD_LENGTH-1:0]   opd1,
    input  logic [OPD_LENGTH-1:0]   opd2,
    input  logic [OPCODE_WIDTH-1:0] alu_op_select,
    output logic [OPD_LENGTH-1:0]   comp_result,
    output logic                    out_valid,
    output logic                    op_illegal
);

    logic    eq;
    logic    ltu;
    logic    lt;
    op_dec_t dec;
    logic    raw_bit;
    logic    result_bit;

    comparison_core #(
        .OPD_LENGTH(OPD_LENGTH)
    ) u_core (
        .opd1(opd1),
        .opd2(opd2),
        .eq  (eq),
        .ltu (ltu),
        .lt  (lt)
    );

    always_comb begin
        dec = decode_op(alu_op_select);
        case (dec.src)
            SRC_EQ:  raw_bit = eq;
            SRC_LTU: raw_bit = ltu;
            SRC_LT:  raw_bit = lt;
            default: raw_bit = 1'b0;
        endcase
        result_bit = dec.legal & (raw_bit ^ dec.invert);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_result <= '0;
            out_valid   <= 1'b0;
            op_illegal  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                comp_result <= {{(OPD_LENGTH-1){1'b0}}, result_bit};
                op_illegal  <= ~dec.legal;
            end
        end
    end

endmodule

// File: tb/tb_comparison_unit.sv
// Directed self-checking bench for comparison_unit at the default 8-bit width.
module tb_comparison_unit;
    import comparison_unit_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] opd1;
    logic [7:0] opd2;
    logic [3:0] alu_op_select;
    logic [7:0] comp_result;
    logic       out_valid;
    logic       op_illegal;

    int checks   = 0;
    int failures = 0;

    logic [3:0] sweep_ops [6];

    comparison_unit #(.OPD_LENGTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .opd1         (opd1),
        .opd2         (opd2),
        .alu_op_select(alu_op_select),
        .comp_result  (comp_result),
        .out_valid    (out_valid),
        .op_illegal   (op_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            opd1          = 8'($urandom);
            opd2          = 8'($urandom);
            alu_op_select = IS_EQ;
            step();
            checks++;
            if (comp_result !== 8'h00 || out_valid !== 1'b0 || op_illegal !== 1'b0) begin
                failures++;
                $display("FAIL reset_during cyc=%0d got res=%h vld=%b ill=%b want res=00 vld=0 ill=0",
                         i, comp_result, out_valid, op_illegal);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (comp_result !== 8'h00 || out_valid !== 1'b0 || op_illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_after got res=%h vld=%b ill=%b want res=00 vld=0 ill=0",
                     comp_result, out_valid, op_illegal);
        end
    endtask

    task automatic test_sweep_zero_zero();
        logic exp [6];
        exp      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        opd1     = 8'h00;
        opd2     = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_op_select = sweep_ops[i];
            step();
            checks++;
            if (comp_result !== {7'b0, exp[i]} || out_valid !== 1'b1 || op_illegal !== 1'b0) begin
                failures++;
                $display("FAIL sweep_00_00 op=%b got res=%h vld=%b ill=%b want res=%h vld=1 ill=0",
                         sweep_ops[i], comp_result, out_valid, op_illegal, {7'b0, exp[i]});
            end
        end
    endtask

    task automatic test_sweep_one_zero();
        logic exp [6];
        exp      = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        opd1     = 8'h01;
        opd2     = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alu_op_select = sweep_ops[i];
            step();
            checks++;
            if (comp_result !== {7'b0, exp[i]} || out_valid !== 1'b1 || op_illegal !== 1'b0) begin
                failures++;
                $display("FAIL sweep_01_00 op=%b got res=%h vld=%b ill=%b want res=%h vld=1 ill=0",
                         sweep_ops[i], comp_result, out_valid, op_illegal, {7'b0, exp[i]});
            end
        end
    endtask

    task automatic test_sweep_ff();
        logic       exp [2][6];
        logic [7:0] b   [2];
        exp = '{'{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
        b   = '{8'hFF, 8'hFE};
        in_valid = 1'b1;
        opd1     = 8'hFF;
        for (int p = 0; p < 2; p++) begin
            opd2 = b[p];
            for (int i = 0; i < 6; i++) begin
                alu_op_select = sweep_ops[i];
                step();
                checks++;
                if (comp_result !== {7'b0, exp[p][i]} || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL sweep_ff_%h op=%b got res=%h vld=%b want res=%h vld=1",
                             b[p], sweep_ops[i], comp_result, out_valid, {7'b0, exp[p][i]});
                end
            end
        end
    endtask

    task automatic test_signed_split();
        logic       exp [2][6];
        logic [7:0] a   [2];
        logic [7:0] b   [2];
        exp = '{'{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
                '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
        a   = '{8'h80, 8'h7F};
        b   = '{8'h7F, 8'h80};
        in_valid = 1'b1;
        for (int p = 0; p < 2; p++) begin
            opd1 = a[p];
            opd2 = b[p];
            for (int i = 0; i < 6; i++) begin
                alu_op_select = sweep_ops[i];
                step();
                checks++;
                if (comp_result !== {7'b0, exp[p][i]} || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL signed_split a=%h b=%h op=%b got res=%h vld=%b want res=%h vld=1",
                             a[p], b[p], sweep_ops[i], comp_result, out_valid, {7'b0, exp[p][i]});
                end
            end
        end
    endtask

    task automatic test_illegal_idle();
        logic [3:0] bad [3];
        bad      = '{4'b0100, 4'b1000, 4'b0101};
        in_valid = 1'b1;
        opd1     = 8'h05;
        opd2     = 8'h05;
        for (int i = 0; i < 3; i++) begin
            alu_op_select = bad[i];
            step();
            checks++;
            if (comp_result !== 8'h00 || op_illegal !== 1'b1 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL illegal op=%b got res=%h ill=%b vld=%b want res=00 ill=1 vld=1",
                         bad[i], comp_result, op_illegal, out_valid);
            end
        end

        // Idle after an illegal request keeps the flag.
        in_valid      = 1'b0;
        alu_op_select = IS_EQ;
        step();
        checks++;
        if (out_valid !== 1'b0 || op_illegal !== 1'b1 || comp_result !== 8'h00) begin
            failures++;
            $display("FAIL idle_after_illegal got vld=%b ill=%b res=%h want vld=0 ill=1 res=00",
                     out_valid, op_illegal, comp_result);
        end

        in_valid      = 1'b1;
        opd1          = 8'h42;
        opd2          = 8'h42;
        alu_op_select = IS_EQ;
        step();
        checks++;
        if (comp_result !== 8'h01 || op_illegal !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL legal_clears got res=%h ill=%b vld=%b want res=01 ill=0 vld=1",
                     comp_result, op_illegal, out_valid);
        end

        // Gap with operands that would give 0 if sampled.
        in_valid      = 1'b0;
        opd1          = 8'h10;
        opd2          = 8'h20;
        alu_op_select = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || comp_result !== 8'h01 || op_illegal !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got vld=%b res=%h ill=%b want vld=0 res=01 ill=0",
                         i, out_valid, comp_result, op_illegal);
            end
        end
    endtask

    initial begin
        sweep_ops     = '{IS_EQ, IS_NE, IS_GE, IS_GEU, IS_LT, IS_LTU};
        rst           = 1'b0;
        in_valid      = 1'b0;
        opd1          = 8'h00;
        opd2          = 8'h00;
        alu_op_select = 4'b0000;
        #1;
        test_reset();
        test_sweep_zero_zero();
        test_sweep_one_zero();
        test_sweep_ff();
        test_signed_split();
        test_illegal_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
